kyber512_pk_loader: RTL and testbench
=====================================

Name: kyber512_pk_loader

Overview:
- Upstream feeder for the Kyber512 encapsulation core.
- Reads the 800-byte public key from a synchronous-read SRAM as 32-bit words and assembles it into the flat 6400-bit bus that drives the core's i_PK input.
- When assembly completes, holds the key stable and raises pk_valid together with a one-cycle kem_enable pulse that starts encapsulation.

Parameters:
- WORD_BITS, 32, SRAM data width; must be a multiple of 8 and divide PK_BYTES*8.
- PK_BYTES, 800, public key length in bytes.
- ADDR_BITS, 10, SRAM word-address width.
- BASE_ADDR, 0, word address of public key byte 0.
- READ_LATENCY, 1, cycles from sram_en/sram_addr to valid sram_rdata; range 1..4.
- Derived: WORDS = PK_BYTES*8/WORD_BITS, which is 200 at defaults.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to load a key.
- clear  in  1  drop pk_valid and return to IDLE.
- sram_en  out  1  SRAM read strobe.
- sram_addr  out  ADDR_BITS  SRAM word address.
- sram_rdata  in  WORD_BITS  SRAM read data.
- busy  out  1  high while a load is in progress.
- pk_valid  out  1  o_PK holds a complete key.
- kem_enable  out  1  one-cycle start pulse to the encapsulation core.
- o_PK  out  PK_BYTES*8  assembled public key.

Behaviour:
- Reset (asynchronous, while rst=1): state IDLE; sram_en=0, sram_addr=0, busy=0, pk_valid=0, kem_enable=0, o_PK=0; issue counter, capture counter and latency pipe cleared.
- Reset asserted mid-load aborts the load immediately; no partial pk_valid is ever produced.
- States are IDLE, FETCH, DRAIN and DONE.
- IDLE: when start=1, go to FETCH and set busy=1.
- FETCH, issue side: sram_en=1 every cycle; sram_addr = BASE_ADDR + issue_cnt with issue_cnt running 0..WORDS-1. After the last address is issued, go to DRAIN.
- Latency pipe: a READ_LATENCY-deep shift register of issue flags marks returning data. When its output is 1, sram_rdata is written into o_PK[cap_cnt*WORD_BITS +: WORD_BITS] and cap_cnt is incremented.
- DRAIN: sram_en=0. When the capture of word WORDS-1 occurs, go to DONE.
- Byte ordering: PK byte i sits at o_PK[8i+7:8i]. Within a word, byte lane j (sram_rdata[8j+7:8j]) is PK byte k*(WORD_BITS/8)+j.
- Entering DONE: pk_valid=1 and busy=0 from the cycle after the last capture. kem_enable=1 for exactly that first DONE cycle only.
- Timing at defaults: start sampled at edge 0. Addresses are issued on cycles 1..200. Captures occur on cycles 1+L..200+L, where L = READ_LATENCY. pk_valid and kem_enable rise at cycle 201+L.
- DONE: o_PK is held constant. clear=1 returns to IDLE with pk_valid=0; o_PK keeps its last value.
- DONE with start=1 (clear=0): restart directly into FETCH; pk_valid drops in the same cycle busy rises.
- Simultaneous start and clear in DONE: clear wins, go to IDLE.
- start while busy is ignored.
- clear while busy is ignored; the load always completes.
- sram_addr wraps modulo 2^ADDR_BITS if BASE_ADDR+WORDS overflows; this is not flagged.
- Counters are $clog2(WORDS+1) bits wide; cap_cnt never exceeds WORDS.

Test Plan:
1. Reset, then pulse start with SRAM word k = {4k+3, 4k+2, 4k+1, 4k} (bytes mod 256), L=1 -> exactly 200 sram_en cycles, addresses 0..199; pk_valid and a single-cycle kem_enable at cycle 202; o_PK[8i+7:8i] = i mod 256 for all i.
2. Same stimulus with READ_LATENCY=3, BASE_ADDR=40 -> addresses 40..239; pk_valid at cycle 204; o_PK identical to scenario 1.
3. Assert rst at cycle 100 of a load, release, then start again with SRAM filled 0xA5 -> outputs are 0 during reset; no pk_valid before reload completes; final o_PK all bytes 0xA5.
4. Pulse start and clear repeatedly during FETCH -> sram_addr sequence is uninterrupted and monotonic; exactly one kem_enable pulse.
5. In DONE, assert clear and start in the same cycle -> IDLE, pk_valid=0, o_PK unchanged. Then start alone -> new load; kem_enable pulses once at completion.
6. In DONE, assert start alone after changing SRAM contents -> pk_valid falls on the next edge, busy rises, and o_PK is updated word by word to the new key.

Source files
------------

// File: rtl/kyber512_pk_loader.sv
`default_nettype none
// ============================================================================
// Module   : kyber512_pk_loader
// Purpose  : Streams the Kyber512 public key out of a synchronous-read SRAM,
//            one word per cycle, and assembles it into the flat bus that
//            feeds the encapsulation core. When the last word lands, the key
//            is held, pk_valid is raised and kem_enable pulses for one cycle.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            start, clear      - load request / drop the held key
//            sram_en/addr/rdata- SRAM read port (READ_LATENCY cycles)
//            busy              - load in progress
//            pk_valid          - o_PK holds a complete key
//            kem_enable        - one-cycle start pulse to the core
//            o_PK              - assembled key, byte i at [8i+7:8i]
// Revision : 1.0 - initial release
// ============================================================================
module kyber512_pk_loader #(
    parameter int WORD_BITS    = 32,
    parameter int PK_BYTES     = 800,
    parameter int ADDR_BITS    = 10,
    parameter int BASE_ADDR    = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear,
    output logic                    sram_en,
    output logic [ADDR_BITS-1:0]    sram_addr,
    input  logic [WORD_BITS-1:0]    sram_rdata,
    output logic                    busy,
    output logic                    pk_valid,
    output logic                    kem_enable,
    output logic [PK_BYTES*8-1:0]   o_PK
);

    localparam int c_PK_BITS = PK_BYTES * 8;
    localparam int c_WORDS   = c_PK_BITS / WORD_BITS;
    localparam int c_CNT_W   = $clog2(c_WORDS + 1);
    localparam int c_IDX_W   = $clog2(c_PK_BITS);

    localparam logic [c_CNT_W-1:0]   c_LAST_WORD = c_CNT_W'(c_WORDS - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [ADDR_BITS-1:0] c_BASE      = ADDR_BITS'(BASE_ADDR);
    localparam logic [ADDR_BITS-1:0] c_ADDR_ONE  = ADDR_BITS'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [c_CNT_W-1:0]      r_issue_cnt;
    logic [c_CNT_W-1:0]      r_cap_cnt;
    logic [READ_LATENCY-1:0] r_pipe;
    logic                    r_sram_en;
    logic [ADDR_BITS-1:0]    r_sram_addr;
    logic                    r_busy;
    logic                    r_pk_valid;
    logic                    r_kem_enable;
    logic [c_PK_BITS-1:0]    r_pk;

    logic                    w_capture;
    logic                    w_last_cap;
    logic [c_IDX_W-1:0]      w_cap_lsb;

    // The pipe output marks the cycle in which sram_rdata carries the word
    // requested READ_LATENCY edges earlier.
    assign w_capture  = r_pipe[READ_LATENCY-1];
    assign w_last_cap = w_capture && (r_cap_cnt == c_LAST_WORD);
    assign w_cap_lsb  = c_IDX_W'(r_cap_cnt) * c_IDX_W'(WORD_BITS);

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_issue_cnt  <= '0;
            r_cap_cnt    <= '0;
            r_pipe       <= '0;
            r_sram_en    <= 1'b0;
            r_sram_addr  <= '0;
            r_busy       <= 1'b0;
            r_pk_valid   <= 1'b0;
            r_kem_enable <= 1'b0;
        end else begin
            r_kem_enable <= 1'b0;

            // The pipe is fed by the strobe the SRAM is sampling this edge.
            r_pipe[0] <= r_sram_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            if (w_capture) begin
                r_cap_cnt <= r_cap_cnt + c_CNT_ONE;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state     <= c_ST_FETCH;
                        r_busy      <= 1'b1;
                        r_sram_en   <= 1'b1;
                        r_sram_addr <= c_BASE;
                        r_issue_cnt <= '0;
                        r_cap_cnt   <= '0;
                    end
                end

                c_ST_FETCH: begin
                    // start/clear are deliberately ignored until the load ends.
                    if (r_issue_cnt == c_LAST_WORD) begin
                        r_sram_en <= 1'b0;
                        r_state   <= c_ST_DRAIN;
                    end else begin
                        r_issue_cnt <= r_issue_cnt + c_CNT_ONE;
                        r_sram_addr <= r_sram_addr + c_ADDR_ONE;  // wraps silently
                    end
                end

                c_ST_DRAIN: begin
                    if (w_last_cap) begin
                        r_state      <= c_ST_DONE;
                        r_busy       <= 1'b0;
                        r_pk_valid   <= 1'b1;
                        r_kem_enable <= 1'b1;
                    end
                end

                c_ST_DONE: begin
                    // clear has priority over a simultaneous start.
                    if (clear) begin
                        r_state    <= c_ST_IDLE;
                        r_pk_valid <= 1'b0;
                    end else if (start) begin
                        r_state     <= c_ST_FETCH;
                        r_pk_valid  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_sram_en   <= 1'b1;
                        r_sram_addr <= c_BASE;
                        r_issue_cnt <= '0;
                        r_cap_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Key assembly: word k lands at bit offset k*WORD_BITS, so byte lane j of
    // word k becomes key byte k*(WORD_BITS/8)+j with no reordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pk <= '0;
        end else if (w_capture) begin
            r_pk[w_cap_lsb +: WORD_BITS] <= sram_rdata;
        end
    end

    assign sram_en    = r_sram_en;
    assign sram_addr  = r_sram_addr;
    assign busy       = r_busy;
    assign pk_valid   = r_pk_valid;
    assign kem_enable = r_kem_enable;
    assign o_PK       = r_pk;

endmodule
`default_nettype wire

// File: tb/tb_kyber512_pk_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_kyber512_pk_loader
// Purpose  : Scoreboard bench for kyber512_pk_loader. Two instances run in
//            lockstep: A (READ_LATENCY=1, BASE_ADDR=0) and
//            B (READ_LATENCY=3, BASE_ADDR=40), each with its own SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kyber512_pk_loader;

    localparam int c_WORDS = 200;
    localparam int c_BYTES = 800;

    typedef struct {
        int             cyc;
        logic [6399:0]  pk;
    } done_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        clear;
    logic        sram_en    [2];
    logic [9:0]  sram_addr  [2];
    logic [31:0] sram_rdata [2];
    logic        busy       [2];
    logic        pk_valid   [2];
    logic        kem_enable [2];
    logic [6399:0] o_pk     [2];

    logic [31:0] mem [2][1024];
    logic [31:0] r_rd_a;
    logic [31:0] r_rd_b [3];

    logic [9:0]  addr_q [2][$];
    done_t       done_q [2][$];
    logic        valid_ok [2];
    logic        prev_kem [2];

    int cyc = 0;
    int n_vec = 0;
    int n_fail = 0;

    kyber512_pk_loader #(
        .WORD_BITS(32), .PK_BYTES(800), .ADDR_BITS(10),
        .BASE_ADDR(0), .READ_LATENCY(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .sram_en(sram_en[0]), .sram_addr(sram_addr[0]), .sram_rdata(sram_rdata[0]),
        .busy(busy[0]), .pk_valid(pk_valid[0]), .kem_enable(kem_enable[0]),
        .o_PK(o_pk[0])
    );

    kyber512_pk_loader #(
        .WORD_BITS(32), .PK_BYTES(800), .ADDR_BITS(10),
        .BASE_ADDR(40), .READ_LATENCY(3)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .sram_en(sram_en[1]), .sram_addr(sram_addr[1]), .sram_rdata(sram_rdata[1]),
        .busy(busy[1]), .pk_valid(pk_valid[1]), .kem_enable(kem_enable[1]),
        .o_PK(o_pk[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models; garbage is driven when not enabled so mistimed captures show.
    always @(posedge clk) begin
        r_rd_a <= sram_en[0] ? mem[0][sram_addr[0]] : 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        r_rd_b[0] <= sram_en[1] ? mem[1][sram_addr[1]] : 32'hDEAD_BEEF;
        r_rd_b[1] <= r_rd_b[0];
        r_rd_b[2] <= r_rd_b[1];
    end
    assign sram_rdata[0] = r_rd_a;
    assign sram_rdata[1] = r_rd_b[2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int base_of(input int d);
        return (d == 0) ? 0 : 40;
    endfunction

    function automatic logic [7:0] pk_byte(input int pat, input int i);
        case (pat)
            0:       return 8'(i % 256);
            1:       return 8'hA5;
            default: return 8'((i * 7 + 3) % 256);
        endcase
    endfunction

    function automatic logic [6399:0] exp_key(input int pat);
        logic [6399:0] k;
        k = '0;
        for (int i = 0; i < c_BYTES; i++) k[8*i +: 8] = pk_byte(pat, i);
        return k;
    endfunction

    task automatic fill(input int pat);
        logic [31:0] w;
        for (int a = 0; a < 1024; a++) begin
            mem[0][a] = 32'hBAD0_0000 | 32'(a);
            mem[1][a] = 32'hBAD1_0000 | 32'(a);
        end
        for (int k = 0; k < c_WORDS; k++) begin
            w = {pk_byte(pat, 4*k+3), pk_byte(pat, 4*k+2),
                 pk_byte(pat, 4*k+1), pk_byte(pat, 4*k)};
            mem[0][k] = w;
            mem[1][(40 + k) % 1024] = w;
        end
    endtask

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    task automatic chk_pk(input string name, input int d, input logic [6399:0] act, input logic [6399:0] exp);
        int idx;
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            idx = -1;
            for (int i = 0; i < c_BYTES; i++)
                if (idx < 0 && act[8*i +: 8] !== exp[8*i +: 8]) idx = i;
            if (idx < 0) idx = 0;
            $display("FAIL %s dut%0d: key byte %0d got %02h expected %02h (cycle %0d)",
                     name, d, idx, act[8*idx +: 8], exp[8*idx +: 8], cyc);
        end
    endtask

    task automatic fail_evt(input string name, input int d);
        n_vec++;
        n_fail++;
        $display("FAIL %s dut%0d: unexpected event at cycle %0d", name, d, cyc);
    endtask

    // Monitor: pops expected addresses on every strobe and expected completions
    // on every kem_enable pulse.
    logic [9:0] mon_addr;
    done_t      mon_it;
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (sram_en[d]) begin
                    if (addr_q[d].size() == 0) fail_evt("extra_sram_en", d);
                    else begin
                        mon_addr = addr_q[d].pop_front();
                        chk("sram_addr", d, 64'(sram_addr[d]), 64'(mon_addr));
                    end
                end
                if (kem_enable[d]) begin
                    if (prev_kem[d]) fail_evt("kem_enable_width", d);
                    else if (done_q[d].size() == 0) fail_evt("spurious_kem_enable", d);
                    else begin
                        mon_it = done_q[d].pop_front();
                        chk("kem_cycle", d, 64'(cyc), 64'(mon_it.cyc));
                        chk("pk_valid_at_kem", d, 64'(pk_valid[d]), 64'd1);
                        chk("busy_at_kem", d, 64'(busy[d]), 64'd0);
                        chk("addr_left_at_kem", d, 64'(addr_q[d].size()), 64'd0);
                        chk_pk("o_PK_at_kem", d, o_pk[d], mon_it.pk);
                        valid_ok[d] = 1'b1;
                    end
                end
                if (pk_valid[d] && !valid_ok[d]) fail_evt("early_pk_valid", d);
                prev_kem[d] = kem_enable[d];
            end
        end
    end

    task automatic start_load(input int pat, output int s);
        done_t it;
        it.pk = exp_key(pat);
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < c_WORDS; k++)
                addr_q[d].push_back(10'((base_of(d) + k) % 1024));
            it.cyc = s + 200 + lat_of(d);
            done_q[d].push_back(it);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        valid_ok[0] = 1'b0;
        valid_ok[1] = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((done_q[0].size() > 0 || done_q[1].size() > 0) && t < 600) begin
            @(posedge clk);
            t++;
        end
        for (int d = 0; d < 2; d++) begin
            if (done_q[d].size() > 0) begin
                fail_evt("load_timeout", d);
                done_q[d].delete();
                addr_q[d].delete();
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int s;
    int offs [6] = '{3, 4, 60, 61, 150, 198};
    logic [6399:0] mix;
    logic [6399:0] newk;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        valid_ok[0] = 1'b0; valid_ok[1] = 1'b0;
        prev_kem[0] = 1'b0; prev_kem[1] = 1'b0;
        fill(0);

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_sram_en", d, 64'(sram_en[d]), 64'd0);
            chk("rst_sram_addr", d, 64'(sram_addr[d]), 64'd0);
            chk("rst_busy", d, 64'(busy[d]), 64'd0);
            chk("rst_pk_valid", d, 64'(pk_valid[d]), 64'd0);
            chk("rst_kem_enable", d, 64'(kem_enable[d]), 64'd0);
            chk_pk("rst_o_PK", d, o_pk[d], '0);
        end
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("idle_busy", d, 64'(busy[d]), 64'd0);

        // Scenario 1/2: incrementing key, both latency/base configurations
        start_load(0, s);
        wait_done();
        for (int d = 0; d < 2; d++) begin
            chk("byte0", d, 64'(o_pk[d][7:0]), 64'h00);
            chk("byte255", d, 64'(o_pk[d][8*255 +: 8]), 64'hFF);
            chk("byte256", d, 64'(o_pk[d][8*256 +: 8]), 64'h00);
            chk("byte799", d, 64'(o_pk[d][8*799 +: 8]), 64'h1F);
        end
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("hold_pk_valid", d, 64'(pk_valid[d]), 64'd1);
            chk("hold_kem_enable", d, 64'(kem_enable[d]), 64'd0);
            chk_pk("hold_o_PK", d, o_pk[d], exp_key(0));
        end

        // Scenario 3: reset mid-load, then reload with 0xA5
        start_load(0, s);
        while (cyc < s + 99) @(negedge clk);
        #2 rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            addr_q[d].delete();
            done_q[d].delete();
            valid_ok[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_sram_en", d, 64'(sram_en[d]), 64'd0);
            chk("midrst_sram_addr", d, 64'(sram_addr[d]), 64'd0);
            chk("midrst_busy", d, 64'(busy[d]), 64'd0);
            chk("midrst_pk_valid", d, 64'(pk_valid[d]), 64'd0);
            chk_pk("midrst_o_PK", d, o_pk[d], '0);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("post_rst_pk_valid", d, 64'(pk_valid[d]), 64'd0);
        fill(1);
        start_load(1, s);
        wait_done();
        for (int d = 0; d < 2; d++) chk("a5_byte400", d, 64'(o_pk[d][8*400 +: 8]), 64'hA5);

        // Scenario 4: start/clear pulses during the load are ignored
        fill(0);
        start_load(0, s);
        for (int i = 0; i < 6; i++) begin
            while (cyc < s + offs[i]) @(negedge clk);
            start = (i % 3 != 1);
            clear = (i % 3 != 0);
            @(posedge clk);
            #1;
            start = 1'b0;
            clear = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("busy_mid_load", d, 64'(busy[d]), 64'd1);
        wait_done();

        // Scenario 5: start+clear together in DONE -> IDLE, key held
        @(negedge clk);
        start = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        valid_ok[0] = 1'b0; valid_ok[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("clr_pk_valid", d, 64'(pk_valid[d]), 64'd0);
            chk("clr_busy", d, 64'(busy[d]), 64'd0);
            chk("clr_sram_en", d, 64'(sram_en[d]), 64'd0);
            chk_pk("clr_o_PK", d, o_pk[d], exp_key(0));
        end
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("idle_after_clr_busy", d, 64'(busy[d]), 64'd0);
        fill(1);
        start_load(1, s);
        wait_done();

        // Scenario 6: restart from DONE with new SRAM contents
        fill(2);
        start_load(2, s);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("restart_pk_valid", d, 64'(pk_valid[d]), 64'd0);
            chk("restart_busy", d, 64'(busy[d]), 64'd1);
            chk_pk("restart_o_PK_old", d, o_pk[d], exp_key(1));
        end
        while (cyc < s + 20) @(negedge clk);
        newk = exp_key(2);
        for (int d = 0; d < 2; d++) begin
            mix = exp_key(1);
            for (int w = 0; w < 20 - lat_of(d); w++) mix[32*w +: 32] = newk[32*w +: 32];
            chk_pk("partial_update", d, o_pk[d], mix);
        end
        wait_done();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
